// File: rtl/audio_pkg.sv
// Shared types and constants for the synth-to-PWM sample path.
// Also holds the 16-bit saturation helper used by audio_fifo_writer.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    SAT   = 2'd2,
    WRITE = 2'd3
  } afw_state_t;

  localparam logic [7:0]  AUDIO_UNITY_GAIN = 8'h80;
  localparam logic [15:0] AUDIO_LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] AUDIO_LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] AUDIO_MIDSCALE   = 16'h8000;

  // Returns {clipped, value} with value clamped to the signed 16-bit range.
  function automatic logic [16:0] sat16(input logic signed [24:0] d);
    logic [16:0] res;
    if (d > 25'sd32767) begin
      res = {1'b1, 16'h7FFF};
    end else if (d < -25'sd32768) begin
      res = {1'b1, 16'h8000};
    end else begin
      res = {1'b0, d[15:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/tpdf_dither_lfsr.sv
// 16-bit Galois LFSR producing per-channel triangular-PDF dither in [-15, 15].
// Each channel's dither is the difference of two uniform 4-bit nibbles.
module tpdf_dither_lfsr
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic signed [4:0] dither_l,
  output logic signed [4:0] dither_r
);

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= AUDIO_LFSR_SEED;
    end else if (advance) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? AUDIO_LFSR_TAPS : 16'h0000);
    end
  end

  assign dither_l = $signed({1'b0, lfsr[3:0]})   - $signed({1'b0, lfsr[7:4]});
  assign dither_r = $signed({1'b0, lfsr[11:8]})  - $signed({1'b0, lfsr[15:12]});

endmodule

// File: rtl/audio_fifo_writer.sv
// Gain-scales stereo samples, saturates, converts to offset binary and writes {R,L} to the dcfifo.
// Define AUDIO_FIFO_WRITER_DITHER_EN to add TPDF dither ahead of saturation.
module audio_fifo_writer
  import audio_pkg::*;
#(
  parameter int CLIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [15:0]           sample_l,
  input  logic [15:0]           sample_r,
  input  logic [7:0]            gain,
  input  logic                  fifo_full,
  output logic                  fifo_wrreq,
  output logic [31:0]           fifo_wrdata,
  output logic [CLIP_CNT_W-1:0] clip_cnt
);

  // Handshake: a sample transfers on a rising edge where sample_valid and
  // sample_ready are both high; upstream holds its data stable until then.

  afw_state_t state;

  logic signed [15:0] cap_l;
  logic signed [15:0] cap_r;
  logic [7:0]         cap_gain;
  logic signed [24:0] s_l;
  logic signed [24:0] s_r;

  logic signed [24:0] p_l;
  logic signed [24:0] p_r;
  logic signed [24:0] d_l;
  logic signed [24:0] d_r;
  logic [16:0]        sat_l;
  logic [16:0]        sat_r;
  logic signed [4:0]  dither_l;
  logic signed [4:0]  dither_r;

  localparam logic [CLIP_CNT_W-1:0] CLIP_ONE = {{(CLIP_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CLIP_CNT_W-1:0] CLIP_MAX = {CLIP_CNT_W{1'b1}};

`ifdef AUDIO_FIFO_WRITER_DITHER_EN
  tpdf_dither_lfsr u_dither (
    .clk      (clk),
    .reset    (reset),
    .advance  (state == SCALE),
    .dither_l (dither_l),
    .dither_r (dither_r)
  );
`else
  assign dither_l = 5'sd0;
  assign dither_r = 5'sd0;
`endif

  // Gain is unsigned Q1.7, so it is zero-extended before the signed multiply.
  assign p_l = $signed({{9{cap_l[15]}}, cap_l}) * $signed({17'b0, cap_gain});
  assign p_r = $signed({{9{cap_r[15]}}, cap_r}) * $signed({17'b0, cap_gain});

  assign d_l = s_l + $signed({{20{dither_l[4]}}, dither_l});
  assign d_r = s_r + $signed({{20{dither_r[4]}}, dither_r});

  assign sat_l = sat16(d_l);
  assign sat_r = sat16(d_r);

  assign sample_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fifo_wrreq  <= 1'b0;
      fifo_wrdata <= {AUDIO_MIDSCALE, AUDIO_MIDSCALE};
      clip_cnt    <= '0;
      cap_l       <= '0;
      cap_r       <= '0;
      cap_gain    <= AUDIO_UNITY_GAIN;
      s_l         <= '0;
      s_r         <= '0;
    end else begin
      fifo_wrreq <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            cap_l    <= sample_l;
            cap_r    <= sample_r;
            cap_gain <= gain;
            state    <= SCALE;
          end
        end
        SCALE: begin
          // Arithmetic shift floors toward negative infinity.
          s_l   <= p_l >>> 7;
          s_r   <= p_r >>> 7;
          state <= SAT;
        end
        SAT: begin
          fifo_wrdata <= {sat_r[15:0] ^ AUDIO_MIDSCALE, sat_l[15:0] ^ AUDIO_MIDSCALE};
          if ((sat_l[16] || sat_r[16]) && (clip_cnt != CLIP_MAX)) begin
            clip_cnt <= clip_cnt + CLIP_ONE;
          end
          state <= WRITE;
        end
        WRITE: begin
          if (!fifo_full) begin
            fifo_wrreq <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
